// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns pc, oldpc, the instruction register and the load-data
// register. Turns the control unit's single-cycle memory strobes into a
// req/ready handshake with wait states, a timeout fault and a stall output
// that holds the control FSM.
//
// Ports:
//   clk, reset (async, active-low)
//   pcwrite, pc_next         PC update from the control unit
//   irwrite, data_rd, memwrite  access strobes (priority memwrite > data_rd > irwrite)
//   adrsrc, data_addr, wdata address select, data address, store data
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready  memory handshake
//   stall                    holds the control FSM while 1
//   pc, oldpc, instr, data   architectural registers
//   op, funct3, funct7b5     decode slices of instr
//   fault                    sticky error flag (timeout or misalignment)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned PC updates and
// misaligned data addresses; otherwise their low two bits are forced to zero.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcwrite,
  input  logic [XLEN-1:0] pc_next,
  input  logic            irwrite,
  input  logic            data_rd,
  input  logic            memwrite,
  input  logic            adrsrc,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] oldpc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] data,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            fault
);

  localparam int unsigned     CntW = $clog2(MAX_WAIT + 1);
  localparam logic [XLEN-1:0] Nop  = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StBusy, StFault} state_e;
  typedef enum logic [1:0] {AccFetch, AccRead, AccWrite} acc_e;

  state_e            state_q, state_d;
  acc_e              acc_q, acc_d;
  logic [XLEN-1:0]   pc_q, pc_d, oldpc_q, oldpc_d, instr_q, instr_d, data_q, data_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic              req_q, req_d, we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              trigger, pc_upd, pc_misalign, addr_misalign;
  logic [XLEN-1:0]   sel_addr, req_addr, pc_next_eff;

  assign trigger  = memwrite | data_rd | irwrite;
  assign sel_addr = adrsrc ? data_addr : pc_q;

  always_comb begin
    stall = 1'b1;
    case (state_q)
      StIdle:  stall = trigger;
      StBusy:  stall = ~mem_ready;
      default: stall = 1'b1;
    endcase
  end

  assign pc_upd = pcwrite & ~stall;

`ifdef MISALIGN_TRAP_EN
  assign pc_next_eff   = pc_next;
  assign req_addr      = sel_addr;
  assign pc_misalign   = pc_upd & (pc_next[1:0] != 2'b00);
  // Only data accesses through data_addr are checked; fetches use the aligned pc.
  assign addr_misalign = (memwrite | data_rd) & adrsrc & (data_addr[1:0] != 2'b00);
`else
  logic unused_lsbs;
  assign unused_lsbs   = ^{pc_next[1:0], sel_addr[1:0]};
  assign pc_next_eff   = {pc_next[XLEN-1:2], 2'b00};
  assign req_addr      = {sel_addr[XLEN-1:2], 2'b00};
  assign pc_misalign   = 1'b0;
  assign addr_misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    oldpc_d = oldpc_q;
    instr_d = instr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    if (pc_upd && !pc_misalign) begin
      pc_d = pc_next_eff;
    end

    case (state_q)
      StIdle: begin
        if (trigger) begin
          if (addr_misalign) begin
            state_d = StFault;
          end else begin
            state_d = StBusy;
            req_d   = 1'b1;
            we_d    = memwrite;
            addr_d  = req_addr;
            wdata_d = wdata;
            cnt_d   = '0;
            if (memwrite) begin
              acc_d = AccWrite;
            end else if (data_rd) begin
              acc_d = AccRead;
            end else begin
              acc_d = AccFetch;
            end
          end
        end
      end
      StBusy: begin
        if (mem_ready) begin
          case (acc_q)
            AccFetch: begin
              instr_d = mem_rdata;
              oldpc_d = pc_q;
            end
            AccRead: data_d = mem_rdata;
            default: ;
          endcase
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          // Last permitted BUSY cycle passed without completion.
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end
    endcase

    if (pc_misalign) begin
      state_d = StFault;
      req_d   = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= AccFetch;
      pc_q    <= RESET_PC;
      oldpc_q <= RESET_PC;
      instr_q <= Nop;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      oldpc_q <= oldpc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc        = pc_q;
  assign oldpc     = oldpc_q;
  assign instr     = instr_q;
  assign data      = data_q;
  assign op        = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7b5  = instr_q[30];
  assign fault     = (state_q == StFault);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control unit.
- Owns PC, OldPC, the instruction register and the read-data register. Drives op/funct3/funct7b5 into the control unit and consumes its pcwrite/irwrite/adrsrc/memwrite strobes.
- Converts single-cycle memory strobes into a req/ready handshake with wait states, a timeout fault and a stall output that holds the control FSM.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- MAX_WAIT, 15, maximum BUSY cycles allowed without mem_ready (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pcwrite  in  1  PC update strobe from control unit.
- pc_next  in  XLEN  next PC value (result bus).
- irwrite  in  1  instruction fetch request.
- data_rd  in  1  load data read request.
- memwrite  in  1  store request.
- adrsrc  in  1  0: address = pc, 1: address = data_addr.
- data_addr  in  XLEN  ALU-computed load/store address.
- wdata  in  XLEN  store data.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  XLEN  registered address.
- mem_wdata  out  XLEN  registered write data.
- mem_rdata  in  XLEN  read data, valid with mem_ready.
- mem_ready  in  1  memory completion.
- stall  out  1  control FSM must hold its state while 1.
- pc  out  XLEN  current PC.
- oldpc  out  XLEN  PC of the instruction in instr.
- instr  out  XLEN  instruction register.
- data  out  XLEN  latched load data.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7b5  out  1  instr[30].
- fault  out  1  sticky error flag.

Behaviour:
- States: IDLE, BUSY, FAULT.
- Reset (async, reset=0):
  - state=IDLE; pc=oldpc=RESET_PC; instr=32'h0000_0013 (NOP, so op=7'h13); data=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0, fault=0.
  - Reset mid-transaction drops mem_req immediately and abandons the access.
- trigger = memwrite | data_rd | irwrite.
  - Priority memwrite > data_rd > irwrite; lower-priority requests in the same cycle are ignored.
- IDLE with trigger:
  - Next edge: state=BUSY, mem_req=1.
  - mem_we=1 only for memwrite.
  - mem_addr = adrsrc ? data_addr : pc.
  - mem_wdata = wdata.
  - Access type latched.
- BUSY:
  - mem_addr, mem_we and mem_wdata are held stable.
  - Each cycle with mem_ready=0, the counter increments.
  - On the edge with mem_ready=1:
    - fetch: instr<=mem_rdata, oldpc<=pc.
    - read: data<=mem_rdata.
    - write: no capture.
    - Then mem_req<=0, mem_we<=0, counter<=0, state=IDLE.
- Timeout: if BUSY cycle number MAX_WAIT has mem_ready=0, next edge goes to FAULT. mem_ready is accepted in BUSY cycles 1..MAX_WAIT.
- FAULT: mem_req=0, fault=1, stall=1; sticky until reset.
- stall (combinational) = FAULT | (BUSY & ~mem_ready) | (IDLE & trigger).
  - stall is 0 on the completion cycle, so the control FSM advances on the same edge as the capture.
- PC update: pc<=pc_next when pcwrite & ~stall.
  - A fetch with concurrent pcwrite (fetch state) therefore updates pc on the completion edge.
  - oldpc captures the pre-update pc on that same edge.
- op/funct3/funct7b5 are pure slices of instr; they change only when instr is written.
- mem_rdata is ignored outside the completion cycle.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: pcwrite & ~stall with pc_next[1:0]!=0 leaves pc unchanged and enters FAULT next edge. A data access with adrsrc=1 and data_addr[1:0]!=0 faults instead of issuing mem_req.
- Undefined: pc_next[1:0] and the address low bits are forced to 2'b00; no fault from alignment.

Test Plan:
- Reset release → pc=0, oldpc=0, instr=0x13, op=0x13, mem_req=0, stall=0, fault=0.
- irwrite=1 and pcwrite=1 with pc_next=4; mem_ready asserted in 3rd BUSY cycle with mem_rdata=0x00500093 → stall high 3 cycles then low; instr=0x00500093, op=0x13, funct3=0, oldpc=0, pc=4 after completion edge.
- data_rd=1, adrsrc=1, data_addr=0x100, mem_rdata=0xDEADBEEF, ready in 1st BUSY cycle → mem_addr=0x100, mem_we=0, data=0xDEADBEEF, pc unchanged.
- memwrite=1 and irwrite=1 together, data_addr=0x200, wdata=0x12345678 → store issued (mem_we=1, mem_addr=0x200, mem_wdata=0x12345678); fetch ignored, instr unchanged.
- irwrite with mem_ready held 0 for 15 BUSY cycles → FAULT, fault=1, stall=1, mem_req=0; later mem_ready=1 has no effect; reset clears.
- Reset asserted in 2nd BUSY cycle → mem_req=0 immediately; after release state IDLE, pc=RESET_PC. With MISALIGN_TRAP_EN: pcwrite, pc_next=0x6 → pc unchanged, fault=1; without: pc=0x4.
